conv_window_gen: RTL and testbench



---
 rtl/conv_window_gen.sv | 133 +++++++++++++
 tb/tb_conv_window_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming K x K x CH sliding-window generator over a raster-order feature map, holding K-1 rows in line buffers.
// Windows appear one cycle after the completing pixel; in_ready drops only while an output window is held unaccepted.
module conv_window_gen #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BITS = 32,
    parameter int CH        = 1,
    parameter int K         = 3,
    parameter int STRIDE    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CH*DATA_BITS-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [K*K*CH*DATA_BITS-1:0]   out_data,
    output logic [15:0]                   out_row,
    output logic [15:0]                   out_col,
    output logic                          out_last
);
    localparam int PW = CH * DATA_BITS;
    localparam int WW = K * K * PW;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int OW = (WIDTH - K) / STRIDE + 1;
    localparam int OH = (HEIGHT - K) / STRIDE + 1;
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [15:0]   KM1     = 16'(K - 1);
    localparam logic [15:0]   STEP    = 16'(STRIDE);
    localparam logic [15:0]   OW_LAST = 16'(OW - 1);
    localparam logic [15:0]   OH_LAST = 16'(OH - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // lb_q[0] holds the oldest row, lb_q[K-2] the row just above the current one
    logic [PW-1:0] lb_q [K-1][WIDTH];
    logic [PW-1:0] new_col [K];
    logic [WW-1:0] win_q, win_d;

    logic          out_valid_q;
    logic [WW-1:0] out_data_q;
    logic [15:0]   out_row_q, out_col_q;
    logic          out_last_q;

    logic          accept;
    logic          emit;
    logic [15:0]   x_off, y_off, col_idx, row_idx;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    always_comb begin
        x_d = x_q + XW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            new_col[i] = lb_q[i][x_q];
        end
        new_col[K-1] = in_data;

        win_d = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[(r*K + c)*PW +: PW] = win_q[(r*K + c + 1)*PW +: PW];
            end
            win_d[(r*K + K - 1)*PW +: PW] = new_col[r];
        end
    end

    // Emits are gated on y >= K-1, so rows left in the buffers by a previous frame never reach the output
    always_comb begin
        x_off   = 16'(x_q) - KM1;
        y_off   = 16'(y_q) - KM1;
        col_idx = x_off / STEP;
        row_idx = y_off / STEP;
        emit    = accept
                  && (16'(x_q) >= KM1) && (16'(y_q) >= KM1)
                  && ((x_off % STEP) == 16'd0)
                  && ((y_off % STEP) == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 2; i++) begin
                lb_q[i][x_q] <= lb_q[i+1][x_q];
            end
            lb_q[K-2][x_q] <= in_data;
            win_q          <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= x_d;
                y_q <= y_d;
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_d;
                out_row_q   <= row_idx;
                out_col_q   <= col_idx;
                out_last_q  <= (row_idx == OH_LAST) && (col_idx == OW_LAST);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 6x5 ramp frame: a stride-1 two-channel instance and a stride-2 single-channel instance,
// with a queue scoreboard per instance checked by independent monitors.
module tb_conv_window_gen;
    localparam int W  = 6;
    localparam int H  = 5;
    localparam int K  = 3;
    localparam int DB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
    logic [63:0]  in_data1;
    logic [575:0] out_data1;
    logic [15:0]  out_row1, out_col1;
    logic         in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [31:0]  in_data2;
    logic [287:0] out_data2;
    logic [15:0]  out_row2, out_col2;

    conv_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .CH(2), .K(K), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1));

    conv_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .CH(1), .K(K), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_row(out_row2), .out_col(out_col2), .out_last(out_last2));

    typedef struct {
        logic [575:0] dat;
        int           row;
        int           col;
        logic         last;
    } exp_t;

    exp_t         q1[$];
    exp_t         q2[$];
    exp_t         e1, e2;
    logic [575:0] seen2[$];
    logic [575:0] last_dat1;
    int           last_row1, last_col1;
    int           total = 0;
    int           bad = 0;
    int           n_win1 = 0, n_last1 = 0, n_win2 = 0, n_last2 = 0;
    int           rdy_mode = 0;
    int           first_w[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int           second_s2[9] = '{2, 3, 4, 8, 9, 10, 14, 15, 16};

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [575:0] act, input logic [575:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int el(input logic [575:0] d, input int idx, input int ch, input int chn);
        return int'(d[(idx*chn + ch)*DB +: DB]);
    endfunction

    // Reference windows straight from the raster definition: channel k of pixel (x,y) is y*W+x+100*k
    task automatic push_frame(input int sel, input int s, input int chn, input int npix);
        int   ow, oh, x, y, v;
        exp_t e;
        ow = (W - K) / s + 1;
        oh = (H - K) / s + 1;
        for (int p = 0; p < npix; p++) begin
            x = p % W;
            y = p / W;
            if (x >= K-1 && y >= K-1 && (x-K+1) % s == 0 && (y-K+1) % s == 0) begin
                e.dat = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        for (int k = 0; k < chn; k++) begin
                            v = (y-K+1+r)*W + (x-K+1+c) + 100*k;
                            e.dat[((r*K + c)*chn + k)*DB +: DB] = 32'(v);
                        end
                e.row  = (y-K+1) / s;
                e.col  = (x-K+1) / s;
                e.last = (e.row == oh-1) && (e.col == ow-1);
                if (sel == 0) q1.push_back(e);
                else          q2.push_back(e);
            end
        end
    endtask

    task automatic send_pix(input int sel, input int v, input int gappct);
        int cnt;
        while (gappct > 0 && int'($urandom_range(99)) < gappct) begin
            @(posedge clk); #1;
        end
        if (sel == 0) begin
            in_valid1 = 1'b1;
            in_data1  = {32'(v + 100), 32'(v)};
        end else begin
            in_valid2 = 1'b1;
            in_data2  = 32'(v);
        end
        cnt = 0;
        forever begin
            @(negedge clk);
            if ((sel == 0) ? in_ready1 : in_ready2) break;
            cnt++;
            if (cnt > 300) begin
                chk_i("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic send_range(input int sel, input int p0, input int p1, input int gappct);
        for (int p = p0; p <= p1; p++) send_pix(sel, p % (W*H), gappct);
    endtask

    task automatic drain(input int sel);
        int cnt = 0;
        while (cnt < 400 && ((sel == 0) ? (q1.size() != 0 || out_valid1) : (q2.size() != 0 || out_valid2))) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk_i("drain_queue_empty", (sel == 0) ? q1.size() : q2.size(), 0);
    endtask

    always begin
        @(posedge clk); #1;
        if (rdy_mode == 0)      out_ready1 = 1'b1;
        else if (rdy_mode == 1) out_ready1 = 1'($urandom_range(1));
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk_i("dut1_unexpected_window", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk_w("dut1_window", out_data1, e1.dat);
                chk_i("dut1_row", int'(out_row1), e1.row);
                chk_i("dut1_col", int'(out_col1), e1.col);
                chk_i("dut1_last", int'(out_last1), int'(e1.last));
            end
            n_win1++;
            if (out_last1) begin
                n_last1++;
                last_dat1 = out_data1;
                last_row1 = int'(out_row1);
                last_col1 = int'(out_col1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                chk_i("dut2_unexpected_window", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk_w("dut2_window", {288'b0, out_data2}, e2.dat);
                chk_i("dut2_row", int'(out_row2), e2.row);
                chk_i("dut2_col", int'(out_col2), e2.col);
                chk_i("dut2_last", int'(out_last2), int'(e2.last));
            end
            n_win2++;
            if (out_last2) n_last2++;
            seen2.push_back({288'b0, out_data2});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, l0, cnt;
        rst = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk_i("reset_out_valid", int'(out_valid1), 0);
        chk_i("reset_out_last", int'(out_last1), 0);
        chk_i("reset_in_ready", int'(in_ready1), 1);
        chk_w("reset_out_data", out_data1, '0);
        chk_i("reset_out_row", int'(out_row1), 0);
        chk_i("reset_out_col", int'(out_col1), 0);

        // continuous frame, stride 1
        push_frame(0, 1, 2, 30);
        w0 = n_win1; l0 = n_last1;
        send_range(0, 0, 13, 0);
        chk_i("t1_no_window_before_pix14", int'(out_valid1), 0);
        send_pix(0, 14, 0);
        chk_i("t1_first_window_valid", int'(out_valid1), 1);
        for (int i = 0; i < 9; i++) chk_i("t1_first_window_elem", el(out_data1, i, 0, 2), first_w[i]);
        send_range(0, 15, 29, 0);
        drain(0);
        chk_i("t1_window_count", n_win1 - w0, 12);
        chk_i("t1_last_count", n_last1 - l0, 1);
        chk_i("t1_last_row", last_row1, 2);
        chk_i("t1_last_col", last_col1, 3);
        chk_i("t1_last_elem8", el(last_dat1, 8, 0, 2), 29);

        // stride 2 on the second instance
        push_frame(1, 2, 1, 30);
        send_range(1, 0, 29, 0);
        drain(1);
        chk_i("t2_window_count", n_win2, 4);
        chk_i("t2_last_count", n_last2, 1);
        if (seen2.size() >= 2) begin
            for (int i = 0; i < 9; i++) chk_i("t2_second_window_elem", el(seen2[1], i, 0, 1), second_s2[i]);
        end else begin
            chk_i("t2_second_window_present", seen2.size(), 2);
        end

        // backpressure after the first window
        rdy_mode = 3;
        out_ready1 = 1'b1;
        push_frame(0, 1, 2, 30);
        w0 = n_win1;
        fork
            send_range(0, 0, 29, 0);
            begin
                cnt = 0;
                do begin
                    @(posedge clk); #1;
                    cnt++;
                end while (!out_valid1 && cnt < 200);
                chk_i("t3_first_window_seen", int'(out_valid1), 1);
                out_ready1 = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk_i("t3_in_ready_low", int'(in_ready1), 0);
                    chk_i("t3_out_valid_held", int'(out_valid1), 1);
                    for (int i = 0; i < 9; i++) chk_i("t3_held_elem", el(out_data1, i, 0, 2), first_w[i]);
                end
                @(posedge clk); #1;
                out_ready1 = 1'b1;
            end
        join
        rdy_mode = 0;
        drain(0);
        chk_i("t3_window_count", n_win1 - w0, 12);

        // random input gaps and random out_ready
        rdy_mode = 1;
        push_frame(0, 1, 2, 30);
        w0 = n_win1; l0 = n_last1;
        send_range(0, 0, 29, 50);
        drain(0);
        rdy_mode = 0;
        chk_i("t4_window_count", n_win1 - w0, 12);
        chk_i("t4_last_count", n_last1 - l0, 1);

        // reset mid-frame after 20 accepts
        push_frame(0, 1, 2, 20);
        send_range(0, 0, 19, 0);
        drain(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_i("t5_out_valid", int'(out_valid1), 0);
        chk_i("t5_out_last", int'(out_last1), 0);
        chk_i("t5_in_ready", int'(in_ready1), 1);
        chk_w("t5_out_data", out_data1, '0);
        chk_i("t5_out_col", int'(out_col1), 0);
        push_frame(0, 1, 2, 30);
        w0 = n_win1; l0 = n_last1;
        send_range(0, 0, 29, 0);
        drain(0);
        chk_i("t5_window_count", n_win1 - w0, 12);
        chk_i("t5_last_count", n_last1 - l0, 1);

        // two back-to-back frames, two channels
        push_frame(0, 1, 2, 30);
        push_frame(0, 1, 2, 30);
        w0 = n_win1; l0 = n_last1;
        send_range(0, 0, 29, 0);
        send_range(0, 0, 13, 0);
        chk_i("t6_no_early_frame2_window", int'(out_valid1), 0);
        send_pix(0, 14, 0);
        chk_i("t6_frame2_first_valid", int'(out_valid1), 1);
        for (int i = 0; i < 9; i++) begin
            chk_i("t6_frame2_first_ch0", el(out_data1, i, 0, 2), first_w[i]);
            chk_i("t6_frame2_first_ch1", el(out_data1, i, 1, 2), first_w[i] + 100);
        end
        send_range(0, 15, 29, 0);
        drain(0);
        chk_i("t6_window_count", n_win1 - w0, 24);
        chk_i("t6_last_count", n_last1 - l0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
